// File: rtl/reg_write_arbiter.sv
// Round-robin req/ack arbiter that is the sole writer of one shared 8-bit enable-loaded register.
// Latency: a request seen at edge t produces ack/reg_enable in the cycle after t; at most one write per 2 cycles.
// Backpressure: requesters hold req until ack; a locked owner may keep the register for up to MAX_BURST writes.
module reg_write_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 2,
  localparam int IW       = (N > 1) ? $clog2(N) : 1,
  localparam int BW       = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    lock,
  input  logic [8*N-1:0]  wdata,
  output logic [N-1:0]    ack,
  output logic            reg_enable,
  output logic [7:0]      reg_data,
  output logic [IW-1:0]   owner,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [IW-1:0]   ptr, ptr_d;
  logic [BW-1:0]   burst_cnt, burst_d;

  // Arbitration result for the coming edge
  logic            rr_hit;
  logic [IW-1:0]   rr_win;
  logic            grant;
  logic [IW-1:0]   win;
  logic            relock;

  // Next values of the registered outputs
  logic [N-1:0]    ack_d;
  logic            enable_d;
  logic [7:0]      data_d;
  logic [IW-1:0]   owner_d;
  logic            busy_d;

  // Round-robin scan starting at ptr; the first requester found wins.
  always_comb begin
    rr_hit = 1'b0;
    rr_win = '0;
    for (int k = 0; k < N; k++) begin
      if (!rr_hit && req[(int'(ptr) + k) % N]) begin
        rr_hit = 1'b1;
        rr_win = IW'((int'(ptr) + k) % N);
      end
    end
  end

  // A locked owner keeps the register only while it still requests and has burst budget left.
  assign relock = lock[owner] && req[owner] && (burst_cnt < BW'(MAX_BURST));

  // Next-state decision: state, round-robin pointer, burst counter and the winner.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    burst_d = burst_cnt;
    grant   = 1'b0;
    win     = owner;
    case (state)
      IDLE: begin
        if (rr_hit) begin
          state_d = WRITE;
          grant   = 1'b1;
          win     = rr_win;
          burst_d = BW'(1);
          ptr_d   = IW'((int'(rr_win) + 1) % N);
        end
      end
      WRITE: begin
        state_d = RECOVER;
      end
      RECOVER: begin
        if (relock) begin
          // Back-to-back write for the locked owner; fairness pointer is left alone.
          state_d = WRITE;
          grant   = 1'b1;
          win     = owner;
          burst_d = burst_cnt + BW'(1);
        end else if (rr_hit) begin
          state_d = WRITE;
          grant   = 1'b1;
          win     = rr_win;
          burst_d = BW'(1);
          ptr_d   = IW'((int'(rr_win) + 1) % N);
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values to be registered: a grant becomes the one-cycle WRITE pulse.
  always_comb begin
    ack_d = '0;
    if (grant) begin
      ack_d[win] = 1'b1;
    end
    enable_d = grant;
    data_d   = grant ? wdata[8*int'(win) +: 8] : reg_data;
    owner_d  = grant ? win : owner;
    busy_d   = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state      <= IDLE;
      ptr        <= '0;
      burst_cnt  <= '0;
      ack        <= '0;
      reg_enable <= 1'b0;
      reg_data   <= 8'h00;
      owner      <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      ptr        <= ptr_d;
      burst_cnt  <= burst_d;
      ack        <= ack_d;
      reg_enable <= enable_d;
      reg_data   <= data_d;
      owner      <= owner_d;
      busy       <= busy_d;
    end
  end

endmodule
